// File: rtl/bufid_release_arbiter.sv
// Packet-buffer-ID release engine: seeds the free-bufid FIFO, then arbitrates
// port releases through a refcount read-modify-write and frees last references.
module bufid_release_arbiter #(
  parameter int NUM_PORTS = 9,
  parameter int BUFID_W   = 9,
  parameter int BUFID_NUM = 512,
  parameter int RSVD_NUM  = 9,
  parameter int REFCNT_W  = 4,
  parameter int RAM_LAT   = 2
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         iv_port_en,
  input  logic [NUM_PORTS*BUFID_W-1:0] iv_pkt_bufid,
  input  logic [NUM_PORTS-1:0]         iv_pkt_bufid_wr,
  output logic [NUM_PORTS-1:0]         ov_pkt_bufid_ack,
  output logic [BUFID_W-1:0]           ov_ram_addr,
  output logic                         o_ram_rd,
  input  logic [REFCNT_W-1:0]          iv_ram_rdata,
  output logic                         o_ram_wr,
  output logic [REFCNT_W-1:0]          ov_ram_wdata,
  output logic                         o_pkt_bufid_wr,
  output logic [BUFID_W-1:0]           ov_pkt_bufid,
  input  logic                         i_pkt_bufid_full,
  output logic                         o_init_done,
  output logic                         o_refcnt_err,
  output logic [31:0]                  ov_free_cnt,
  output logic [2:0]                   ov_state
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = BUFID_W + 1;
  localparam int LW = $clog2(RAM_LAT + 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_ARB  = 3'd1,
    S_WAIT = 3'd2,
    S_DEC  = 3'd3,
    S_PUSH = 3'd4
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]        rr;
  logic [CW-1:0]        icnt;
  logic [LW-1:0]        wcnt;
  logic [NUM_PORTS-1:0] cand;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [PW:0]          pos;
  logic [BUFID_W-1:0]   sel_bufid;
  logic                 init_end;
  logic                 wait_end;

  assign cand     = iv_pkt_bufid_wr & iv_port_en;
  assign init_end = (icnt == CW'(BUFID_NUM));
  assign wait_end = (wcnt == LW'(RAM_LAT - 1));
  assign ov_state = state;

  // first candidate at or after rr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = {1'b0, rr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_PORTS))
        pos = pos - (PW+1)'(NUM_PORTS);
      if (!gnt_vld && cand[pos[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_bufid = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (gnt_idx == PW'(k))
        sel_bufid = iv_pkt_bufid[k*BUFID_W +: BUFID_W];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT: if (init_end) state_n = S_ARB;
      S_ARB:  if (gnt_vld) state_n = S_WAIT;
      S_WAIT: if (wait_end) state_n = S_DEC;
      S_DEC:
        state_n = (iv_ram_rdata == REFCNT_W'(1)) ? S_PUSH : S_ARB;
      S_PUSH: if (!i_pkt_bufid_full) state_n = S_ARB;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_n;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rr               <= '0;
      icnt             <= CW'(RSVD_NUM);
      wcnt             <= '0;
      ov_pkt_bufid_ack <= '0;
      ov_ram_addr      <= '0;
      o_ram_rd         <= 1'b0;
      o_ram_wr         <= 1'b0;
      ov_ram_wdata     <= '0;
      o_pkt_bufid_wr   <= 1'b0;
      ov_pkt_bufid     <= '0;
      o_init_done      <= 1'b0;
      o_refcnt_err     <= 1'b0;
      ov_free_cnt      <= '0;
    end else begin
      ov_pkt_bufid_ack <= '0;
      o_ram_rd         <= 1'b0;
      o_ram_wr         <= 1'b0;
      o_pkt_bufid_wr   <= 1'b0;
      unique case (state)
        S_INIT: begin
          if (init_end) begin
            o_init_done <= 1'b1;
          end else if (!i_pkt_bufid_full) begin
            o_pkt_bufid_wr <= 1'b1;
            ov_pkt_bufid   <= icnt[BUFID_W-1:0];
            icnt           <= icnt + 1'b1;
          end
        end
        S_ARB: begin
          if (gnt_vld) begin
            ov_pkt_bufid_ack <= NUM_PORTS'(1) << gnt_idx;
            ov_ram_addr      <= sel_bufid;
            o_ram_rd         <= 1'b1;
            wcnt             <= '0;
            rr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0
                                                 : gnt_idx + 1'b1;
          end
        end
        S_WAIT: wcnt <= wcnt + 1'b1;
        S_DEC: begin
          // count 1 frees the id without a write; allocator rewrites on reuse
          if (iv_ram_rdata > REFCNT_W'(1)) begin
            o_ram_wr     <= 1'b1;
            ov_ram_wdata <= iv_ram_rdata - 1'b1;
          end else if (iv_ram_rdata == '0) begin
            o_refcnt_err <= 1'b1;
          end
        end
        S_PUSH: begin
          if (!i_pkt_bufid_full) begin
            o_pkt_bufid_wr <= 1'b1;
            ov_pkt_bufid   <= ov_ram_addr;
            ov_free_cnt    <= ov_free_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
